uart_frame_loader: RTL and testbench
====================================

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 Parameter ADDR_W, default 19: width of frame-buffer address.
REQ-002 Parameter FRAME_PIXELS, default 307200: bytes per frame (640x480, 8-bit pixel); SHALL be <= 2**ADDR_W.
REQ-003 Parameter SYNC0, default 8'hAA: first frame-header byte.
REQ-004 Parameter SYNC1, default 8'h55: second frame-header byte.
REQ-005 Parameter TIMEOUT_CYC, default 5_000_000: max idle clocks between payload bytes (100 ms at 50 MHz).
REQ-006 Parameter DOUBLE_BUF, default 1: 1 = ping-pong banks, 0 = single bank (bank outputs tied 0).
REQ-007 Port clk_50, input, 1: sole clock.
REQ-008 Port rst, input, 1: reset, synchronous and active-high.
REQ-009 Port data_in, input, 8: received UART byte.
REQ-010 Port data_valid, input, 1: one-cycle strobe qualifying data_in.
REQ-011 Port wr_addr, output, ADDR_W: frame-buffer write address.
REQ-012 Port wr_data, output, 8: frame-buffer write data.
REQ-013 Port wr_en, output, 1: frame-buffer write enable.
REQ-014 Port wr_bank, output, 1: bank being written (memory address MSB).
REQ-015 Port disp_bank, output, 1: bank holding last complete frame, for the VGA reader.
REQ-016 Port frame_done, output, 1: one-cycle pulse on frame completion.
REQ-017 Port err_timeout, output, 1: one-cycle pulse on payload timeout.
REQ-018 Port busy, output, 1: high while in LOAD.

Function
REQ-019 FSM states HUNT0, HUNT1, LOAD; all transitions on data_valid or timeout only.
REQ-020 HUNT0: data_valid with data_in==SYNC0 -> HUNT1; other bytes dropped, no write.
REQ-021 HUNT1: data_in==SYNC1 -> LOAD with byte counter=0; data_in==SYNC0 -> stay HUNT1; other byte -> HUNT0.
REQ-022 LOAD: each data_valid writes data_in; wr_en, wr_data, wr_addr registered, asserted exactly one cycle after the strobe; wr_addr = byte counter value before increment.
REQ-023 Header bytes are never written; bytes equal to SYNC0/SYNC1 inside LOAD are payload.
REQ-024 On the write of byte index FRAME_PIXELS-1: frame_done pulses in the same cycle as that wr_en; FSM -> HUNT0; counter clears.
REQ-025 On frame completion with DOUBLE_BUF=1: disp_bank <= wr_bank and wr_bank toggles, both effective on the cycle after frame_done; never changes mid-frame.
REQ-026 Idle counter clears on every data_valid in LOAD, increments otherwise; reaching TIMEOUT_CYC -> err_timeout one-cycle pulse, FSM -> HUNT0, counter clears, banks unchanged (partial frame discarded from display).
REQ-027 Timeout counter inactive (held 0) in HUNT0/HUNT1.
REQ-028 Simultaneous data_valid and timeout terminal count: byte wins, counter clears, no err_timeout.
REQ-029 wr_addr SHALL never reach FRAME_PIXELS; counter width ADDR_W, no wrap inside frame.
REQ-030 busy = (state==LOAD).

Reset
REQ-031 rst (synchronous, active-high) SHALL force: state HUNT0, counters 0, wr_en 0, wr_addr 0, wr_data 0, wr_bank 0, disp_bank 0 when DOUBLE_BUF=1, frame_done 0, err_timeout 0.
REQ-032 rst mid-LOAD abandons the frame; no write issued in the cycle after rst even if data_valid was high with rst.

Structure
REQ-033 Shared package holds state encoding and default constants (SYNC0, SYNC1, 640x480 FRAME_PIXELS, 50 MHz TIMEOUT_CYC).
REQ-034 Sub-module frame_timeout_ctr (load/clear/terminal-count counter) is permitted; FSM and write port stay in uart_frame_loader.

Verification (FRAME_PIXELS=4, TIMEOUT_CYC=16, DOUBLE_BUF=1)
REQ-035 Bytes AA,55,10,20,30,40 -> writes (0,10),(1,20),(2,30),(3,40), each one cycle after strobe; frame_done with addr 3; then wr_bank=1, disp_bank=0.
REQ-036 Bytes 12,AA,AA,55,01,02,03,04 -> only 01..04 written at addr 0..3; 12 and header dropped.
REQ-037 AA,55,01,02 then 16 idle cycles -> err_timeout one pulse, busy 0, banks unchanged; next AA,55,.. restarts at addr 0.
REQ-038 Two full frames back-to-back -> wr_bank 0,1,0 sequence, disp_bank 0 then 1; payload bytes AA/55 written as data.
REQ-039 rst asserted with data_valid after 2 payload bytes -> no wr_en next cycle, all outputs at reset values, resync required.
REQ-040 data_valid on cycle 16 of idle in LOAD -> byte written, no err_timeout.

Source files
------------

// File: rtl/uart_frame_loader_pkg.sv
// Shared state encoding and default constants for the UART frame loader.
package uart_frame_loader_pkg;

    // Default geometry: 640x480 frame with 8-bit pixels.
    localparam int unsigned DEF_H_PIXELS     = 640;
    localparam int unsigned DEF_V_PIXELS     = 480;
    localparam int unsigned DEF_FRAME_PIXELS = DEF_H_PIXELS * DEF_V_PIXELS;
    localparam int unsigned DEF_ADDR_W       = 19;

    // Default frame header bytes.
    localparam logic [7:0] DEF_SYNC0 = 8'hAA;
    localparam logic [7:0] DEF_SYNC1 = 8'h55;

    // Default payload timeout: 100 ms at 50 MHz.
    localparam int unsigned DEF_TIMEOUT_CYC = 5_000_000;

    typedef enum logic [1:0] {
        ST_HUNT0 = 2'd0,
        ST_HUNT1 = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Counter width able to hold values 0..limit-1.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_loader_timeout_ctr.sv
// Idle-cycle counter: counts enabled cycles and flags the terminal count.
module frame_timeout_ctr
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_c_o
);

    localparam int unsigned CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count is reached on the LIMIT-th consecutive enabled cycle.
    assign tc_c_o = (cnt_q == LAST_CNT);

    // Count while enabled; clear on request or when the terminal count is consumed.
    always_ff @(posedge clk) begin
        if (rst || clr_i || (en_i && tc_c_o)) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Hunts for a two-byte header in a UART byte stream and streams the following
// payload into a (optionally ping-pong) frame buffer.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter logic [7:0]  SYNC0        = DEF_SYNC0,
    parameter logic [7:0]  SYNC1        = DEF_SYNC1,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter bit          DOUBLE_BUF   = 1'b1
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              wr_bank,
    output logic              disp_bank,
    output logic              frame_done,
    output logic              err_timeout,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] byte_cnt_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              wr_en_q;
    logic              wr_bank_q;
    logic              disp_bank_q;
    logic              frame_done_q;
    logic              err_timeout_q;

    logic in_load_c;
    logic idle_en_c;
    logic idle_clr_c;
    logic idle_tc_c;

    // Idle counter only runs inside LOAD and restarts on every received byte.
    assign in_load_c  = (state_q == ST_LOAD);
    assign idle_en_c  = in_load_c && !data_valid;
    assign idle_clr_c = !in_load_c || data_valid;

    frame_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk    (clk_50),
        .rst    (rst),
        .en_i   (idle_en_c),
        .clr_i  (idle_clr_c),
        .tc_c_o (idle_tc_c)
    );

    // Header hunt, payload write port, bank swap and status pulses.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q       <= ST_HUNT0;
            byte_cnt_q    <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            disp_bank_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;

            // Banks swap the cycle after frame_done, so the last write still hits the old bank.
            if (DOUBLE_BUF && frame_done_q) begin
                disp_bank_q <= wr_bank_q;
                wr_bank_q   <= ~wr_bank_q;
            end

            case (state_q)
                ST_HUNT0: begin
                    if (data_valid && (data_in == SYNC0)) begin
                        state_q <= ST_HUNT1;
                    end
                end
                ST_HUNT1: begin
                    if (data_valid) begin
                        if (data_in == SYNC1) begin
                            state_q    <= ST_LOAD;
                            byte_cnt_q <= '0;
                        end else if (data_in != SYNC0) begin
                            state_q <= ST_HUNT0;
                        end
                    end
                end
                ST_LOAD: begin
                    // A byte arriving on the terminal idle cycle takes priority over the timeout.
                    if (data_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= byte_cnt_q;
                        wr_data_q <= data_in;
                        if (byte_cnt_q == LAST_IDX) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_HUNT0;
                            byte_cnt_q   <= '0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + ADDR_W'(1);
                        end
                    end else if (idle_tc_c) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_HUNT0;
                        byte_cnt_q    <= '0;
                    end
                end
                default: begin
                    state_q <= ST_HUNT0;
                end
            endcase
        end
    end

    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_en       = wr_en_q;
    assign wr_bank     = wr_bank_q;
    assign disp_bank   = disp_bank_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;
    assign busy        = in_load_c;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized and directed bench for uart_frame_loader against a stream-level model.
module tb_uart_frame_loader;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned FP     = 4;
    localparam int unsigned TO     = 16;
    localparam logic [7:0]  S0     = 8'hAA;
    localparam logic [7:0]  S1     = 8'h55;

    logic              clk_50 = 1'b0;
    logic              rst;
    logic [7:0]        data_in;
    logic              data_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              wr_bank;
    logic              disp_bank;
    logic              frame_done;
    logic              err_timeout;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream-level model state.
    bit m_in_frame;
    bit m_saw_sync0;
    int m_idx;
    int m_idle;
    bit m_wbank;
    bit m_dbank;
    bit m_swap_pending;

    // Expected outputs after the current edge.
    bit          e_wr_en;
    int          e_addr;
    logic [7:0]  e_data;
    bit          e_done;
    bit          e_to;

    uart_frame_loader #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FP),
        .SYNC0        (S0),
        .SYNC1        (S1),
        .TIMEOUT_CYC  (TO),
        .DOUBLE_BUF   (1'b1)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .disp_bank   (disp_bank),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit r, input bit v, input logic [7:0] d);
        e_wr_en = 1'b0;
        e_done  = 1'b0;
        e_to    = 1'b0;
        if (r) begin
            m_in_frame = 0; m_saw_sync0 = 0; m_idx = 0; m_idle = 0;
            m_wbank = 0; m_dbank = 0; m_swap_pending = 0;
            e_addr = 0; e_data = 8'h00;
            return;
        end
        if (m_swap_pending) begin
            m_dbank = m_wbank;
            m_wbank = ~m_wbank;
            m_swap_pending = 0;
        end
        if (m_in_frame) begin
            if (v) begin
                e_wr_en = 1'b1;
                e_addr  = m_idx;
                e_data  = d;
                m_idx++;
                m_idle  = 0;
                if (m_idx == FP) begin
                    e_done = 1'b1;
                    m_in_frame = 0;
                    m_swap_pending = 1;
                    m_idx = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    e_to = 1'b1;
                    m_in_frame = 0;
                    m_idle = 0;
                    m_idx = 0;
                end
            end
        end else if (v) begin
            if (m_saw_sync0 && d == S1) begin
                m_in_frame = 1; m_saw_sync0 = 0; m_idx = 0; m_idle = 0;
            end else begin
                m_saw_sync0 = (d == S0);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en) begin
            check_eq("wr_addr", 32'(wr_addr), 32'(e_addr));
            check_eq("wr_data", 32'(wr_data), 32'(e_data));
        end
        check_eq("frame_done", 32'(frame_done), 32'(e_done));
        check_eq("err_timeout", 32'(err_timeout), 32'(e_to));
        check_eq("busy", 32'(busy), 32'(m_in_frame));
        check_eq("wr_bank", 32'(wr_bank), 32'(m_wbank));
        check_eq("disp_bank", 32'(disp_bank), 32'(m_dbank));
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] d);
        rst = r; data_valid = v; data_in = d;
        @(posedge clk_50);
        model_step(r, v, d);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        idle(2);

        // Basic frame, then bank swap.
        send(8'hAA); send(8'h55); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        idle(2);
        check_eq("swap1_wr_bank", 32'(wr_bank), 32'd1);
        check_eq("swap1_disp_bank", 32'(disp_bank), 32'd0);

        // Junk and repeated SYNC0 before header.
        send(8'h12); send(8'hAA); send(8'hAA); send(8'h55);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);

        // Timeout after partial frame, then clean restart.
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02);
        idle(18);
        send(8'hAA); send(8'h55); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        idle(2);

        // Byte on the terminal idle cycle wins over the timeout.
        send(8'hAA); send(8'h55); send(8'h01);
        idle(15); send(8'h02);
        idle(15); send(8'h03); send(8'h04);
        idle(2);

        // Back-to-back frames with header values as payload.
        send(8'hAA); send(8'h55); send(8'hAA); send(8'h55); send(8'hAA); send(8'h55);
        send(8'hAA); send(8'h55); send(8'h55); send(8'hAA); send(8'h55); send(8'hAA);
        idle(2);

        // Reset coinciding with a payload strobe abandons the frame.
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02);
        cycle(1'b1, 1'b1, 8'h03);
        check_eq("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_mid_wr_bank", 32'(wr_bank), 32'd0);
        send(8'h04); send(8'h05); idle(3);
        send(8'hAA); send(8'h55); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            logic [7:0] b;
            sel = int'($urandom_range(0, 3));
            b = (sel == 0) ? S0 : (sel == 1) ? S1 : 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                cycle(1'b1, 1'($urandom_range(0, 1)), b);
            end else if ($urandom_range(0, 39) == 0) begin
                idle(int'($urandom_range(10, 20)));
            end else begin
                cycle(1'b0, ($urandom_range(0, 9) < 6), b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
